// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: round-robin scheduler of dot-product jobs onto one DSP48A1 slice.
// Optional stall timeout in RUN is enabled with `define DSP_SEQ_TIMEOUT_EN.
module dsp_mac_sequencer #(
    parameter int NREQ     = 2,
    parameter int LEN_W    = 8,
    parameter int PIPE_LAT = 3,
    parameter int OPM_DLY  = 2,
    parameter int TIMEOUT  = 255,
    localparam int IW      = $clog2(NREQ),
    localparam int DW      = $clog2(PIPE_LAT + 1)
) (
    input  logic                  CLK,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*LEN_W-1:0] req_len,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ-1:0]       op_valid,
    input  logic [NREQ*18-1:0]    op_a,
    input  logic [NREQ*18-1:0]    op_b,
    output logic [NREQ-1:0]       op_ready,
    output logic [17:0]           dsp_a,
    output logic [17:0]           dsp_b,
    output logic [7:0]            dsp_opmode,
    output logic                  dsp_ce,
    input  logic [47:0]           dsp_p,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [IW-1:0]         res_id,
    output logic [47:0]           res_data,
    output logic                  res_err
);
    typedef enum logic [2:0] {IDLE, ARB, RUN, DRAIN, DONE} state_t;
    state_t state, nstate;
    logic [IW-1:0]    g, ptr, sel;
    logic [LEN_W-1:0] len, cnt;
    logic [DW-1:0]    dcnt;
    logic [7:0]       opm_in;
    logic [7:0]       dly [OPM_DLY];
    logic             xfer, tmo;
    assign res_valid  = state == DONE;
    assign res_id     = g;
    assign dsp_opmode = dly[OPM_DLY-1];
`ifdef DSP_SEQ_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT + 1);
    logic [SW-1:0] stall;
    logic          err;
    assign tmo     = state == RUN && !xfer && stall == SW'(TIMEOUT - 1);
    assign res_err = err;
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            stall <= '0;
            err   <= 1'b0;
        end else begin
            if (state == ARB || xfer)
                stall <= '0;
            else if (state == RUN)
                stall <= stall + SW'(1);
            if (state == ARB)
                err <= 1'b0;
            else if (tmo)
                err <= 1'b1;
        end
    end
`else
    assign tmo     = 1'b0;
    assign res_err = 1'b0;
`endif
    always_ff @(posedge CLK or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= nstate;
    end
    always_comb begin
        nstate    = state;
        req_ready = '0;
        op_ready  = '0;
        xfer      = 1'b0;
        dsp_a     = '0;
        dsp_b     = '0;
        dsp_ce    = 1'b0;
        opm_in    = 8'h09;
        sel       = ptr;
        // Descending scan so the requester closest after ptr wins.
        for (int i = NREQ; i >= 1; i--) begin
            int idx;
            idx = (int'(ptr) + i) % NREQ;
            if (req_valid[idx])
                sel = IW'(idx);
        end
        case (state)
            IDLE:  nstate = |req_valid ? ARB : IDLE;
            ARB: begin
                req_ready[g] = req_valid[g];
                nstate = !req_valid[g] ? IDLE :
                         req_len[g*LEN_W +: LEN_W] == '0 ? DONE : RUN;
            end
            RUN: begin
                op_ready[g] = 1'b1;
                xfer   = op_valid[g];
                dsp_ce = xfer;
                dsp_a  = xfer ? op_a[g*18 +: 18] : '0;
                dsp_b  = xfer ? op_b[g*18 +: 18] : '0;
                opm_in = cnt == '0 ? 8'h01 : 8'h09;
                nstate = (xfer && cnt == len - LEN_W'(1)) || tmo ? DRAIN : RUN;
            end
            DRAIN: begin
                dsp_ce = dcnt != DW'(PIPE_LAT);
                nstate = dcnt == DW'(PIPE_LAT) ? DONE : DRAIN;
            end
            DONE:  nstate = res_ready ? IDLE : DONE;
            default: nstate = IDLE;
        endcase
    end
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            g        <= '0;
            ptr      <= IW'(NREQ - 1);
            len      <= '0;
            cnt      <= '0;
            dcnt     <= '0;
            res_data <= '0;
            dly      <= '{default: '0};
        end else begin
            if (state == IDLE)
                g <= sel;
            if (state == ARB) begin
                ptr      <= g;
                len      <= req_len[g*LEN_W +: LEN_W];
                cnt      <= '0;
                dcnt     <= '0;
                res_data <= '0;
            end
            if (xfer)
                cnt <= cnt + LEN_W'(1);
            if (state == DRAIN && dcnt != DW'(PIPE_LAT))
                dcnt <= dcnt + DW'(1);
            // A job that timed out before any transfer never loaded the accumulator.
            if (state == DRAIN && dcnt == DW'(PIPE_LAT))
                res_data <= cnt == '0 ? '0 : dsp_p;
            if (dsp_ce) begin
                dly[0] <= opm_in;
                for (int i = 1; i < OPM_DLY; i++)
                    dly[i] <= dly[i-1];
            end
        end
    end
endmodule
